// File: rtl/fifo_rd_stream_if.sv
// Bundles the fifo_sync read-port signals and the outgoing valid/ready stream.
// master: the read stage itself; slave: the FIFO/consumer side.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_cs;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic [1:0]            buf_level;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_cs, fifo_rd_en, m_valid, m_data, m_last, buf_level
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_cs, fifo_rd_en, m_valid, m_data, m_last, buf_level
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read stage for fifo_sync: pops 1-cycle-latency FIFO words into a 3-slot registered
// buffer and presents them as a valid/ready stream with fixed-size burst framing.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8
) (
    input logic             clk,
    input logic             rst,
    fifo_rd_stream_if.master bus
);
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] mem [3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            level;
    logic                  rd_en_q;
    logic                  inflight;
    logic [CW-1:0]         beat_cnt;

    logic                  push;
    logic                  pop;
    logic                  rd_en_d;
    logic [2:0]            credit;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit ignores the pop so m_ready never reaches fifo_rd_en combinationally.
    always_comb begin
        push    = inflight;
        pop     = (level != 2'd0) && bus.m_ready;
        credit  = {1'b0, level} + {2'b00, inflight} + {2'b00, rd_en_q};
        rd_en_d = !bus.fifo_empty && (credit < 3'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q  <= 1'b0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            beat_cnt <= '0;
        end else begin
            rd_en_q  <= rd_en_d;
            // fifo_sync ignores a read against an empty flag, so no word comes back for it.
            inflight <= rd_en_q && !bus.fifo_empty;
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr   <= next_ptr(rd_ptr);
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= bus.fifo_data;
        end
    end

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.fifo_cs    = rd_en_q;
    assign bus.m_valid    = (level != 2'd0);
    assign bus.m_data     = (level != 2'd0) ? mem[rd_ptr] : '0;
    assign bus.m_last     = (level != 2'd0) && (beat_cnt == LAST_BEAT);
    assign bus.buf_level  = level;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised bench for fifo_rd_stream: a queue-based fifo_sync model feeds the DUT and a
// scoreboard checks stream order, burst tagging, stall stability and reset flushing.
module tb_fifo_rd_stream;
    localparam int DW = 32;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW-1:0] fq[$];        // words still inside fifo_sync
    logic [DW-1:0] exp_q[$];     // words popped from fifo_sync, not yet handed over
    logic [DW-1:0] last_words[$];
    int            hs_cyc[$];
    int            reads_acc = 0;
    int            hs_cnt    = 0;
    bit            run_mon   = 0;
    bit            prev_hold = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // fifo_sync model: registered data_out and registered empty flag
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
    end
    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (bus.fifo_rd_en === 1'b1 && bus.fifo_empty === 1'b0 && fq.size() > 0) begin
            w = fq.pop_front();
            bus.fifo_data <= w;
            reads_acc++;
            exp_q.push_back(w);
        end
        if (rst) begin
            exp_q.delete();
            hs_cnt = 0;
        end
        bus.fifo_empty <= (fq.size() == 0);
    end

    // Stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (run_mon) begin
            check("cs_eq_rden", bus.fifo_cs, bus.fifo_rd_en);
            check("valid_vs_level", bus.m_valid, bus.buf_level != 2'd0);
            check("no_overflow", exp_q.size() <= 3, 1);
            if (prev_hold) begin
                check("hold_valid", bus.m_valid, 1);
                check("hold_data", bus.m_data, prev_data);
                check("hold_last", bus.m_last, prev_last);
            end
            if (bus.m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 0, 1);
                end else begin
                    check("m_data", bus.m_data, exp_q[0]);
                    check("m_last", bus.m_last, hs_cnt == BL - 1);
                end
                if (bus.m_ready && !rst) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    hs_cyc.push_back(cyc);
                    if (bus.m_last) last_words.push_back(bus.m_data);
                    hs_cnt = (hs_cnt + 1) % BL;
                end
            end else begin
                check("idle_last", bus.m_last, 0);
            end
            prev_hold = bus.m_valid && !bus.m_ready && !rst;
            prev_data = bus.m_data;
            prev_last = bus.m_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc, input bit toggle, input string tag);
        int n = 0;
        while ((fq.size() != 0 || exp_q.size() != 0 || bus.buf_level != 2'd0) && n < max_cyc) begin
            if (toggle) bus.m_ready = !bus.m_ready;
            step();
            n++;
        end
        check(tag, n < max_cyc, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int first_rd = -1;
        int first_v  = -1;
        int r0;
        int n;

        bus.m_ready = 1'b1;
        fq.push_back(32'd1);
        fq.push_back(32'd10);
        fq.push_back(32'd100);

        // Reset held two clocks with a non-empty FIFO
        rst = 1'b1;
        step();
        run_mon = 1;
        for (int i = 0; i < 2; i++) begin
            check("rst_rd_en", bus.fifo_rd_en, 0);
            check("rst_valid", bus.m_valid, 0);
            check("rst_level", bus.buf_level, 0);
            check("rst_data", bus.m_data, 0);
            check("rst_last", bus.m_last, 0);
            if (i == 0) step();
        end
        check("rst_fifo_nonempty", bus.fifo_empty, 0);
        hs_cyc.delete();
        rst = 1'b0;

        // Three preloaded words, latency and back-to-back delivery
        for (int i = 0; i < 12; i++) begin
            step();
            if (first_rd < 0 && bus.fifo_rd_en) first_rd = cyc;
            if (first_v < 0 && bus.m_valid) first_v = cyc;
        end
        check("t2_latency", first_v - first_rd, 2);
        check("t2_count", hs_cyc.size(), 3);
        if (hs_cyc.size() >= 3) begin
            check("t2_gap01", hs_cyc[1] - hs_cyc[0], 1);
            check("t2_gap12", hs_cyc[2] - hs_cyc[1], 1);
        end
        drain(20, 0, "t2_drain");

        // Consumer stalled: exactly three reads fill the buffer
        bus.m_ready = 1'b0;
        r0 = reads_acc;
        for (int i = 0; i < 8; i++) fq.push_back($urandom);
        for (int i = 0; i < 12; i++) step();
        check("t3_reads", reads_acc - r0, 3);
        check("t3_level", bus.buf_level, 3);
        check("t3_rd_en", bus.fifo_rd_en, 0);
        bus.m_ready = 1'b1;
        drain(60, 0, "t3_drain");

        // Burst tagging from a fresh beat count
        pulse_reset();
        last_words.delete();
        for (int i = 0; i < 8; i++) fq.push_back(32'd1 << i);
        drain(60, 0, "t4_drain");
        check("t4_last_count", last_words.size(), 2);
        if (last_words.size() == 2) begin
            check("t4_last0", last_words[0], 8);
            check("t4_last1", last_words[1], 128);
        end

        // Reset while a read is returning and two words are buffered
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fq.push_back($urandom);
        n = 0;
        while (bus.buf_level != 2'd2 && n < 20) begin
            step();
            n++;
        end
        check("t5_reach_level2", n < 20, 1);
        check("t5_inflight", exp_q.size(), 3);
        pulse_reset();
        check("t5_valid", bus.m_valid, 0);
        check("t5_level", bus.buf_level, 0);
        bus.m_ready = 1'b1;
        drain(60, 0, "t5_drain");

        // Toggling ready, 16 words
        for (int i = 0; i < 16; i++) fq.push_back($urandom);
        drain(200, 1, "t6_drain");

        // Random ready and random arrival
        for (int i = 0; i < 300; i++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) fq.push_back($urandom);
            step();
        end
        bus.m_ready = 1'b1;
        drain(300, 0, "rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
